// File: rtl/uart_transmitter_sequencer.sv
// Purpose: captures an ALU result (RESULT_BYTES bytes) or one register-file byte and
//   feeds it to a UART transmitter one byte at a time over a valid/busy handshake.
// Latency: a capture on edge N presents the first byte with valid high right after edge N.
//   Backpressure: busy high acknowledges the byte, busy low completes it, and a
//   watchdog drops the frame if busy never rises.
// Ports:
//   clk, reset (sync, active-low)
//   ALU_result_valid / ALU_result      wide result capture (takes priority)
//   read_data_valid / read_data        single-byte capture
//   transmitter_busy_synchronized      transmitter busy, already in the clk domain
//   transmitter_parallel_data(_valid)  byte request to the transmitter
//   UART_receiver_controller_enable    high when a new command may be accepted
//   frame_done, timeout_error          one-cycle status pulses
module uart_transmitter_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_BYTES = 2,
  parameter int MSB_FIRST    = 0,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ALU_result_valid,
  input  logic [RESULT_BYTES*DATA_WIDTH-1:0] ALU_result,
  input  logic                               read_data_valid,
  input  logic [DATA_WIDTH-1:0]              read_data,
  input  logic                               transmitter_busy_synchronized,
  output logic [DATA_WIDTH-1:0]              transmitter_parallel_data,
  output logic                               transmitter_parallel_data_valid,
  output logic                               UART_receiver_controller_enable,
  output logic                               frame_done,
  output logic                               timeout_error
);

  localparam int RW = RESULT_BYTES * DATA_WIDTH;
  localparam int CW = $clog2(RESULT_BYTES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t                state, state_nx;
  logic [RW-1:0]         shreg, shreg_nx, shreg_adv;
  logic [CW-1:0]         count, count_nx;
  logic [TW-1:0]         wdog, wdog_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic                  valid_nx, enable_nx, done_nx, terr_nx;
  logic                  busy;

  assign busy = transmitter_busy_synchronized;

  // Register advanced by one byte toward whichever end is transmitted next.
  always_comb begin
    if (MSB_FIRST != 0) shreg_adv = shreg << DATA_WIDTH;
    else                shreg_adv = shreg >> DATA_WIDTH;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                           <= IDLE;
      shreg                           <= '0;
      count                           <= '0;
      wdog                            <= '0;
      transmitter_parallel_data       <= '0;
      transmitter_parallel_data_valid <= 1'b0;
      UART_receiver_controller_enable <= 1'b1;
      frame_done                      <= 1'b0;
      timeout_error                   <= 1'b0;
    end else begin
      state                           <= state_nx;
      shreg                           <= shreg_nx;
      count                           <= count_nx;
      wdog                            <= wdog_nx;
      transmitter_parallel_data       <= data_nx;
      transmitter_parallel_data_valid <= valid_nx;
      UART_receiver_controller_enable <= enable_nx;
      frame_done                      <= done_nx;
      timeout_error                   <= terr_nx;
    end
  end

  // Outputs are computed for the next state so that every output is a register.
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    count_nx  = count;
    wdog_nx   = wdog;
    data_nx   = transmitter_parallel_data;
    valid_nx  = 1'b0;
    enable_nx = 1'b0;
    done_nx   = 1'b0;
    terr_nx   = 1'b0;
    case (state)
      IDLE: begin
        enable_nx = !busy;
        // Valids seen while the transmitter is busy are dropped, not queued.
        if (!busy) begin
          if (ALU_result_valid) begin
            shreg_nx  = ALU_result;
            count_nx  = CW'(RESULT_BYTES);
            data_nx   = (MSB_FIRST != 0) ? ALU_result[RW-1 -: DATA_WIDTH]
                                         : ALU_result[DATA_WIDTH-1:0];
            wdog_nx   = '0;
            valid_nx  = 1'b1;
            enable_nx = 1'b0;
            state_nx  = SEND;
          end else if (read_data_valid) begin
            // The data register is loaded directly, so byte order never applies here.
            shreg_nx  = RW'(read_data);
            count_nx  = CW'(1);
            data_nx   = read_data;
            wdog_nx   = '0;
            valid_nx  = 1'b1;
            enable_nx = 1'b0;
            state_nx  = SEND;
          end
        end
      end
      SEND: begin
        if (busy) begin
          wdog_nx  = '0;
          state_nx = WAIT_DONE;
        end else if (wdog == TW'(ACK_TIMEOUT)) begin
          // Transmitter never took the byte: abandon the whole frame.
          wdog_nx   = '0;
          count_nx  = '0;
          terr_nx   = 1'b1;
          enable_nx = 1'b1;
          state_nx  = IDLE;
        end else begin
          wdog_nx  = wdog + TW'(1);
          valid_nx = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          count_nx = count - CW'(1);
          shreg_nx = shreg_adv;
          if (count == CW'(1)) begin
            done_nx   = 1'b1;
            enable_nx = 1'b1;
            state_nx  = IDLE;
          end else begin
            data_nx  = (MSB_FIRST != 0) ? shreg_adv[RW-1 -: DATA_WIDTH]
                                        : shreg_adv[DATA_WIDTH-1:0];
            wdog_nx  = '0;
            valid_nx = 1'b1;
            state_nx = SEND;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/uart_transmitter_sequencer.md
# uart_transmitter_sequencer

Multi-byte, parametrised successor to the system controller's UART transmit path. Captures either a wide ALU result (RESULT_BYTES bytes) or a single register-file read byte, then feeds the UART transmitter one byte at a time using a valid/busy handshake. The transmitter's busy flag arrives already synchronised into the reference clock domain. A watchdog aborts any byte the transmitter never accepts.

## Interface
- DATA_WIDTH, 8: width of one UART byte.
- RESULT_BYTES, 2: number of bytes in ALU_result, 1..8.
- MSB_FIRST, 0: 0 sends ALU_result[DATA_WIDTH-1:0] first; 1 sends the top byte first.
- ACK_TIMEOUT, 1024: reference-clock cycles allowed for busy to rise after valid is asserted; width is $clog2(ACK_TIMEOUT+1).

- clk  in  1  reference clock.
- reset  in  1  synchronous, active-low reset.
- ALU_result_valid  in  1  ALU_result is valid this cycle.
- ALU_result  in  RESULT_BYTES*DATA_WIDTH  result to transmit.
- read_data_valid  in  1  read_data is valid this cycle.
- read_data  in  DATA_WIDTH  register-file read byte.
- transmitter_busy_synchronized  in  1  transmitter busy, already synchronised to clk.
- transmitter_parallel_data  out  DATA_WIDTH  byte presented to the transmitter.
- transmitter_parallel_data_valid  out  1  byte request to the transmitter.
- UART_receiver_controller_enable  out  1  high when a new command may be accepted.
- frame_done  out  1  one-cycle pulse after the last byte of a frame completes.
- timeout_error  out  1  one-cycle pulse when a frame is aborted by the watchdog.

## Operation
- States: IDLE, SEND, WAIT_DONE.
- IDLE
  - Captures a frame only when transmitter_busy_synchronized=0.
  - ALU_result_valid has priority. When it is high, ALU_result goes into the shift register and the byte counter loads RESULT_BYTES.
  - Otherwise, when read_data_valid is high, read_data goes into the lowest byte and the counter loads 1.
  - A valid arriving while busy=1 is ignored; it is not queued.
  - A capture moves the FSM to SEND.
- SEND
  - transmitter_parallel_data_valid=1 and transmitter_parallel_data holds the current byte.
  - The watchdog counts up each cycle.
  - When busy=1 is sampled, go to WAIT_DONE and clear the watchdog.
  - When the watchdog reaches ACK_TIMEOUT with busy still 0, pulse timeout_error, drop valid and return to IDLE. The frame is discarded.
- WAIT_DONE
  - Valid=0 and the data output holds its last value.
  - On busy=0: decrement the counter and shift the register by DATA_WIDTH toward the next byte.
  - If the remaining count is then 0, pulse frame_done and go to IDLE. Otherwise go to SEND.
  - There is no timeout in this state; the transmitter always completes a byte.
- Byte order
  - MSB_FIRST=0: bytes go out in order [7:0], [15:8], and so on.
  - MSB_FIRST=1: the top byte goes first.
  - Single-byte read frames are unaffected by MSB_FIRST.
- UART_receiver_controller_enable is a registered output: 1 in IDLE when busy=0, otherwise 0.
- Every output is registered.

## Timing
- Reset values: FSM=IDLE, transmitter_parallel_data=0, transmitter_parallel_data_valid=0, UART_receiver_controller_enable=1, frame_done=0, timeout_error=0, counters=0.
- Reset asserted mid-frame: all outputs return to their reset values at the next edge and the frame is dropped.
- Capture latency: a valid sampled at edge N gives transmitter_parallel_data_valid=1 and the byte on the data output from edge N+1. UART_receiver_controller_enable=0 from edge N+1.
- Busy handling:
  - Busy sampled high at edge M gives valid=0 from edge M+1.
  - Busy sampled low in WAIT_DONE at edge K gives the next byte with valid=1 from edge K+1.
  - For the last byte, frame_done=1 for the cycle after edge K and enable=1 from edge K+1.
- Timeout: timeout_error pulses exactly ACK_TIMEOUT+1 cycles after valid rises, provided busy never rose.
- Simultaneous ALU_result_valid and read_data_valid: the ALU frame is taken and read_data is lost.
- Back-to-back frames: a new capture is possible at the earliest edge after the FSM returns to IDLE.

## Test plan
- Two-byte ALU frame (defaults): ALU_result=16'hE7A6 with valid. Model raises busy 3 cycles after valid and drops it 40 cycles later. Required: byte A6 then E7, two valid pulses, one frame_done, enable=0 throughout the frame.
- Read-data frame: read_data=8'h79 with valid. Required: a single byte 79, then frame_done, then enable=1.
- Priority: both valids in the same cycle with ALU_result=16'h1234 and read_data=8'h55. Required: 34 then 12; 55 is never sent.
- MSB_FIRST=1, RESULT_BYTES=4, ALU_result=32'hDEADBEEF. Required: DE, AD, BE, EF, then one frame_done.
- Timeout with ACK_TIMEOUT=16 and busy held at 0. Required: valid high for 17 cycles, a one-cycle timeout_error pulse, IDLE, enable=1, no frame_done.
- Reset mid-frame: assert reset during the second byte. Required: at the next edge valid=0, data=0, enable=1. A subsequent frame with 16'h00FF sends FF then 00 correctly.
